ram_arbiter: RTL and testbench

//   Shares the single-port 256x16 block RAM between two requesters: port 0 (TinyMIPS CPU)
//   and port 1 (host loader/debug). Grants at most one access per cycle. Round-robin

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/ram_arbiter.sv | 100 ++++++++++
 tb/tb_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port block RAM arbiter: owner encoding and
// default RAM geometry.
package ram_arbiter_pkg;

   localparam int RAM_ADDR_W = 8;
   localparam int RAM_DATA_W = 16;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_P0   = 2'd1,
      OWN_P1   = 2'd2
   } owner_e;

   // The port that is not p; only meaningful for OWN_P0/OWN_P1.
   function automatic owner_e other_port(input owner_e p);
      return (p == OWN_P0) ? OWN_P1 : OWN_P0;
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bundle of the two requester ports and the blram-facing bus of the arbiter.
// master = the system around the arbiter (CPU, host, blram); slave = the arbiter.
interface ram_arbiter_if
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W
);

   logic              req0;
   logic              we0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] wdata0;
   logic              gnt0;
   logic              rvalid0;
   logic [DATA_W-1:0] rdata0;

   logic              req1;
   logic              we1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata1;
   logic              gnt1;
   logic              rvalid1;
   logic [DATA_W-1:0] rdata1;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_din;
   logic [DATA_W-1:0] ram_dout;

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output ram_dout,
      input  gnt0, rvalid0, rdata0,
      input  gnt1, rvalid1, rdata1,
      input  ram_we, ram_addr, ram_din
   );

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  ram_dout,
      output gnt0, rvalid0, rdata0,
      output gnt1, rvalid1, rdata1,
      output ram_we, ram_addr, ram_din
   );

endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between the CPU (port 0)
// and the host loader (port 1), with a bounded hold so neither port starves.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W   = RAM_ADDR_W,
   parameter int DATA_W   = RAM_DATA_W,
   parameter int MAX_HOLD = 4
) (
   input logic          clk,
   input logic          rst,
   ram_arbiter_if.slave bus
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

   owner_e            owner_reg;
   owner_e            last_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [1:0]        rv_reg;

   owner_e            sel;
   logic [1:0]        gnt;
   logic              ram_we_next;
   logic [ADDR_W-1:0] ram_addr_next;
   logic [DATA_W-1:0] ram_din_next;

   // hold_cnt saturates at HOLD_LIM, so "below the limit" is simply "not at it".
   always_comb begin
      sel = OWN_NONE;
      if (rst) begin
         case (owner_reg)
            OWN_P0: begin
               if (bus.req0 && (!bus.req1 || hold_cnt_reg != HOLD_LIM)) sel = OWN_P0;
               else if (bus.req1)                                       sel = OWN_P1;
            end
            OWN_P1: begin
               if (bus.req1 && (!bus.req0 || hold_cnt_reg != HOLD_LIM)) sel = OWN_P1;
               else if (bus.req0)                                       sel = OWN_P0;
            end
            default: begin
               if (bus.req0 && bus.req1) sel = other_port(last_reg);
               else if (bus.req0)        sel = OWN_P0;
               else if (bus.req1)        sel = OWN_P1;
            end
         endcase
      end
   end

   always_comb begin
      gnt           = 2'b00;
      ram_we_next   = 1'b0;
      ram_addr_next = '0;
      ram_din_next  = '0;
      case (sel)
         OWN_P0: begin
            gnt           = 2'b01;
            ram_we_next   = bus.we0;
            ram_addr_next = bus.addr0;
            ram_din_next  = bus.wdata0;
         end
         OWN_P1: begin
            gnt           = 2'b10;
            ram_we_next   = bus.we1;
            ram_addr_next = bus.addr1;
            ram_din_next  = bus.wdata1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_reg    <= OWN_NONE;
         last_reg     <= OWN_P1;
         hold_cnt_reg <= '0;
         rv_reg       <= 2'b00;
      end else begin
         owner_reg <= sel;
         if (sel != OWN_NONE) last_reg <= sel;
         if (sel == OWN_NONE || sel != owner_reg) hold_cnt_reg <= '0;
         else if (hold_cnt_reg != HOLD_LIM)       hold_cnt_reg <= hold_cnt_reg + 1'b1;
         // Read data comes back from blram one cycle later; tag it to the granted port.
         rv_reg[0] <= gnt[0] & ~bus.we0;
         rv_reg[1] <= gnt[1] & ~bus.we1;
      end
   end

   assign bus.gnt0     = gnt[0];
   assign bus.gnt1     = gnt[1];
   assign bus.ram_we   = ram_we_next;
   assign bus.ram_addr = ram_addr_next;
   assign bus.ram_din  = ram_din_next;
   assign bus.rvalid0  = rv_reg[0];
   assign bus.rvalid1  = rv_reg[1];
   assign bus.rdata0   = bus.ram_dout;
   assign bus.rdata1   = bus.ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two lanes (MAX_HOLD=4 and MAX_HOLD=1), each with its own
// blram model, driven by randomized requesters and checked against a streak-based model.
module tb_ram_arbiter;

   localparam int NL = 2;
   localparam int AW = 8;
   localparam int DW = 16;

   localparam int M_IDLE  = 0;
   localparam int M_CONT  = 1;
   localparam int M_ONLY1 = 2;
   localparam int M_RAND  = 3;

   typedef struct packed {
      logic          v;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } rq_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NL-1:0] req0, we0, req1, we1;
   logic [AW-1:0] addr0 [NL];
   logic [AW-1:0] addr1 [NL];
   logic [DW-1:0] wdata0 [NL];
   logic [DW-1:0] wdata1 [NL];
   logic [NL-1:0] gnt0, gnt1, rvalid0, rvalid1, ram_we;
   logic [DW-1:0] rdata0 [NL];
   logic [DW-1:0] rdata1 [NL];
   logic [AW-1:0] ram_addr [NL];
   logic [DW-1:0] ram_din [NL];

   int n_vec = 0;
   int n_err = 0;

   function automatic logic [DW-1:0] init_val(input int a);
      return (a == 5) ? 16'h1234 : 16'((a * 257) ^ 32'h5A5A);
   endfunction

   genvar gi;
   for (gi = 0; gi < NL; gi++) begin : g_lane
      ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
      logic [DW-1:0] mem [256];
      logic [DW-1:0] dout;

      initial for (int i = 0; i < 256; i++) mem[i] <= init_val(i);

      always @(posedge clk) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
         dout <= mem[bus.ram_addr];
      end

      assign bus.ram_dout = dout;
      assign bus.req0     = req0[gi];
      assign bus.we0      = we0[gi];
      assign bus.addr0    = addr0[gi];
      assign bus.wdata0   = wdata0[gi];
      assign bus.req1     = req1[gi];
      assign bus.we1      = we1[gi];
      assign bus.addr1    = addr1[gi];
      assign bus.wdata1   = wdata1[gi];
      assign gnt0[gi]     = bus.gnt0;
      assign gnt1[gi]     = bus.gnt1;
      assign rvalid0[gi]  = bus.rvalid0;
      assign rvalid1[gi]  = bus.rvalid1;
      assign rdata0[gi]   = bus.rdata0;
      assign rdata1[gi]   = bus.rdata1;
      assign ram_we[gi]   = bus.ram_we;
      assign ram_addr[gi] = bus.ram_addr;
      assign ram_din[gi]  = bus.ram_din;

      ram_arbiter #(
         .ADDR_W  (AW),
         .DATA_W  (DW),
         .MAX_HOLD((gi == 0) ? 4 : 1)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .bus(bus)
      );
   end

   // Reference model: who was granted last cycle and how many times in a row.
   int            maxh [NL] = '{4, 1};
   int            prev_g [NL];
   int            streak [NL];
   int            last_g [NL];
   logic [DW-1:0] mmem [NL][256];
   logic          pend_v [NL][2];
   logic [DW-1:0] pend_d [NL][2];
   rq_t           cur [NL][2];
   int            sidx [NL][2];
   rq_t           script0 [$];
   rq_t           script1 [$];
   int            mode;

   task automatic chk(input string tag, input int lane, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s lane%0d: got %0h expected %0h at %0t", tag, lane, got, exp, $time);
      end
   endtask

   function automatic rq_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rq_t r;
      r.v = 1'b1; r.we = we; r.addr = a; r.wdata = d;
      return r;
   endfunction

   task automatic pick(input int l, input int p, output rq_t r);
      r = '0;
      if (p == 0 && sidx[l][0] < script0.size()) begin
         r = script0[sidx[l][0]];
         sidx[l][0]++;
      end else if (p == 1 && sidx[l][1] < script1.size()) begin
         r = script1[sidx[l][1]];
         sidx[l][1]++;
      end else begin
         r.addr  = 8'($urandom_range(0, 15));
         r.wdata = 16'($urandom);
         case (mode)
            M_CONT:  r.v = 1'b1;
            M_ONLY1: begin r.v = (p == 1); r.we = 1'($urandom_range(0, 1)); end
            M_RAND:  begin r.v = ($urandom_range(0, 3) != 0); r.we = 1'($urandom_range(0, 1)); end
            default: r.v = 1'b0;
         endcase
      end
   endtask

   function automatic int model_grant(input int l);
      int p, o;
      if (prev_g[l] >= 0) begin
         p = prev_g[l];
         o = 1 - p;
         if (cur[l][p].v && (!cur[l][o].v || streak[l] < maxh[l])) return p;
         if (cur[l][o].v) return o;
         return -1;
      end
      if (cur[l][0].v && cur[l][1].v) return 1 - last_g[l];
      if (cur[l][0].v) return 0;
      if (cur[l][1].v) return 1;
      return -1;
   endfunction

   // Async reset entered just after a clock edge, released on a negedge with a new phase.
   task automatic do_reset(input int m);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      for (int l = 0; l < NL; l++) begin
         chk("rst_gnt0", l, 32'(gnt0[l]), 32'(0));
         chk("rst_gnt1", l, 32'(gnt1[l]), 32'(0));
         chk("rst_rvalid0", l, 32'(rvalid0[l]), 32'(0));
         chk("rst_rvalid1", l, 32'(rvalid1[l]), 32'(0));
         chk("rst_ram_we", l, 32'(ram_we[l]), 32'(0));
         chk("rst_ram_addr", l, 32'(ram_addr[l]), 32'(0));
         chk("rst_ram_din", l, 32'(ram_din[l]), 32'(0));
      end
      @(negedge clk);
      @(negedge clk);
      rst  = 1'b1;
      mode = m;
      $display("[%0t] reset released, mode %0d", $time, m);
      for (int l = 0; l < NL; l++) begin
         prev_g[l] = -1;
         streak[l] = 0;
         last_g[l] = 1;
         for (int p = 0; p < 2; p++) begin
            pend_v[l][p] = 1'b0;
            sidx[l][p]   = 0;
            pick(l, p, cur[l][p]);
         end
      end
   endtask

   task automatic step();
      int g;
      logic          e_we;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_din;
      for (int l = 0; l < NL; l++) begin
         req0[l] = cur[l][0].v; we0[l] = cur[l][0].we; addr0[l] = cur[l][0].addr; wdata0[l] = cur[l][0].wdata;
         req1[l] = cur[l][1].v; we1[l] = cur[l][1].we; addr1[l] = cur[l][1].addr; wdata1[l] = cur[l][1].wdata;
      end
      #2;
      for (int l = 0; l < NL; l++) begin
         g = model_grant(l);
         e_we = 1'b0; e_addr = '0; e_din = '0;
         if (g >= 0) begin
            e_we = cur[l][g].we; e_addr = cur[l][g].addr; e_din = cur[l][g].wdata;
         end
         chk("gnt0", l, 32'(gnt0[l]), 32'(g == 0));
         chk("gnt1", l, 32'(gnt1[l]), 32'(g == 1));
         chk("ram_we", l, 32'(ram_we[l]), 32'(e_we));
         chk("ram_addr", l, 32'(ram_addr[l]), 32'(e_addr));
         chk("ram_din", l, 32'(ram_din[l]), 32'(e_din));
         chk("rvalid0", l, 32'(rvalid0[l]), 32'(pend_v[l][0]));
         chk("rvalid1", l, 32'(rvalid1[l]), 32'(pend_v[l][1]));
         if (pend_v[l][0]) chk("rdata0", l, 32'(rdata0[l]), 32'(pend_d[l][0]));
         if (pend_v[l][1]) chk("rdata1", l, 32'(rdata1[l]), 32'(pend_d[l][1]));
         pend_v[l][0] = 1'b0;
         pend_v[l][1] = 1'b0;
         if (g >= 0) begin
            $display("[%0t] lane%0d port%0d %s addr=%02h data=%04h", $time, l, g,
                     e_we ? "WR" : "RD", e_addr, e_we ? e_din : mmem[l][e_addr]);
            if (e_we) mmem[l][e_addr] = e_din;
            else begin
               pend_v[l][g] = 1'b1;
               pend_d[l][g] = mmem[l][e_addr];
            end
            streak[l] = (g == prev_g[l]) ? streak[l] + 1 : 1;
            prev_g[l] = g;
            last_g[l] = g;
         end else begin
            prev_g[l] = -1;
            streak[l] = 0;
         end
         for (int p = 0; p < 2; p++)
            if (p == g || !cur[l][p].v) pick(l, p, cur[l][p]);
      end
      @(negedge clk);
   endtask

   initial begin
      req0 = '0; we0 = '0; req1 = '0; we1 = '0;
      for (int l = 0; l < NL; l++) begin
         addr0[l] = '0; addr1[l] = '0; wdata0[l] = '0; wdata1[l] = '0;
         for (int a = 0; a < 256; a++) mmem[l][a] = init_val(a);
      end

      // Directed: single read of a preloaded word, then write/read-back on port 1.
      script0.push_back(mk(1'b0, 8'h05, 16'h0000));
      script1.push_back(mk(1'b1, 8'h10, 16'hBEEF));
      script1.push_back(mk(1'b0, 8'h10, 16'h0000));
      do_reset(M_IDLE);
      repeat (6) step();
      script0.delete();
      script1.delete();

      // Both ports reading back to back: tie from reset, then hold bound.
      do_reset(M_CONT);
      repeat (20) step();

      // Port 1 alone: no hold-limit gaps.
      do_reset(M_ONLY1);
      repeat (12) step();

      do_reset(M_RAND);
      repeat (400) step();

      // Reset straight after random traffic, then a fresh tie.
      do_reset(M_CONT);
      repeat (6) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
